branch_ctrl: RTL

- Multi-cycle branch/jump resolution controller that sequences the shared branch comparator for BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL and JALR.
- Captures one request, drives the comparator from registered operands, and computes target and link addresses.
- Reports a resolve result and holds a redirect to fetch until fetch accepts it.
- Sits between decode/issue and the fetch PC mux.

---
 rtl/branch_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch/jump resolution controller driving the shared comparator
// Optional perf counters enabled by defining BRANCH_CTRL_PERF_EN.
module branch_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_kind_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [DATA_WIDTH-1:0] req_pc_i,
    input  logic [DATA_WIDTH-1:0] req_imm_i,
    input  logic [DATA_WIDTH-1:0] req_rs1_i,
    input  logic [DATA_WIDTH-1:0] req_rs2_i,
    output logic [DATA_WIDTH-1:0] cmp_rs1_o,
    output logic [DATA_WIDTH-1:0] cmp_rs2_o,
    output logic [2:0]            cmp_funct3_o,
    input  logic                  cmp_flag_i,
    output logic                  resolve_valid_o,
    output logic                  resolve_taken_o,
    output logic                  resolve_exc_o,
    output logic [DATA_WIDTH-1:0] link_data_o,
    output logic                  redirect_valid_o,
    output logic [DATA_WIDTH-1:0] redirect_pc_o,
`ifdef BRANCH_CTRL_PERF_EN
    output logic [31:0]           perf_taken_cnt_o,
    output logic [31:0]           perf_ntaken_cnt_o,
`endif
    input  logic                  redirect_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EVAL  = 2'd1,
        S_RESP  = 2'd2,
        S_REDIR = 2'd3
    } state_t;

    localparam logic [1:0] KIND_JAL  = 2'd1;
    localparam logic [1:0] KIND_JALR = 2'd2;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]            r_kind;
    logic [2:0]            r_funct3;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_imm;
    logic [DATA_WIDTH-1:0] r_rs1;
    logic [DATA_WIDTH-1:0] r_rs2;

    logic                  r_resolve_valid;
    logic                  r_resolve_taken;
    logic                  r_resolve_exc;
    logic [DATA_WIDTH-1:0] r_link;
    logic                  r_redirect_valid;
    logic [DATA_WIDTH-1:0] r_redirect_pc;

    logic                  w_accept;
    logic                  w_is_jump;
    logic                  w_cond_ok;
    logic                  w_taken;
    logic [DATA_WIDTH-1:0] w_target;
    logic                  w_exc;
    logic [DATA_WIDTH-1:0] w_link;

    assign req_ready_o = (r_state == S_IDLE);
    assign w_accept    = req_valid_i && req_ready_o && !flush_i;

    // funct3 2/3 have no branch meaning; force not-taken regardless of the comparator
    assign w_is_jump = (r_kind == KIND_JAL) || (r_kind == KIND_JALR);
    assign w_cond_ok = (r_funct3[2:1] != 2'b01);
    assign w_taken   = w_is_jump || (cmp_flag_i && w_cond_ok);
    assign w_target  = (r_kind == KIND_JALR)
                     ? ((r_rs1 + r_imm) & {{(DATA_WIDTH-1){1'b1}}, 1'b0})
                     : (r_pc + r_imm);
    assign w_exc     = w_taken && w_target[1];
    assign w_link    = r_pc + DATA_WIDTH'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (req_valid_i) w_state_nxt = S_EVAL;
                S_EVAL:  w_state_nxt = (w_taken && !w_exc) ? S_REDIR : S_RESP;
                S_RESP:  w_state_nxt = S_IDLE;
                S_REDIR: if (redirect_ready_i) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kind           <= '0;
            r_funct3         <= '0;
            r_pc             <= '0;
            r_imm            <= '0;
            r_rs1            <= '0;
            r_rs2            <= '0;
            r_resolve_valid  <= 1'b0;
            r_resolve_taken  <= 1'b0;
            r_resolve_exc    <= 1'b0;
            r_link           <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else if (flush_i) begin
            r_kind           <= '0;
            r_funct3         <= '0;
            r_pc             <= '0;
            r_imm            <= '0;
            r_rs1            <= '0;
            r_rs2            <= '0;
            r_resolve_valid  <= 1'b0;
            r_resolve_taken  <= 1'b0;
            r_resolve_exc    <= 1'b0;
            r_link           <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_resolve_valid <= 1'b0;
            if (w_accept) begin
                r_kind   <= req_kind_i;
                r_funct3 <= req_funct3_i;
                r_pc     <= req_pc_i;
                r_imm    <= req_imm_i;
                r_rs1    <= req_rs1_i;
                r_rs2    <= req_rs2_i;
            end
            case (r_state)
                S_EVAL: begin
                    r_resolve_valid <= 1'b1;
                    r_resolve_taken <= w_taken;
                    r_resolve_exc   <= w_exc;
                    r_link          <= w_link;
                    if (w_taken && !w_exc) begin
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= w_target;
                    end
                end
                S_REDIR: begin
                    if (redirect_ready_i) begin
                        r_redirect_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmp_rs1_o        = r_rs1;
    assign cmp_rs2_o        = r_rs2;
    assign cmp_funct3_o     = r_funct3;
    assign resolve_valid_o  = r_resolve_valid;
    assign resolve_taken_o  = r_resolve_taken;
    assign resolve_exc_o    = r_resolve_exc;
    assign link_data_o      = r_link;
    assign redirect_valid_o = r_redirect_valid;
    assign redirect_pc_o    = r_redirect_pc;

`ifdef BRANCH_CTRL_PERF_EN
    logic [31:0] r_perf_taken;
    logic [31:0] r_perf_ntaken;

    // Only plain conditional branches are counted; flush does not clear history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_taken  <= '0;
            r_perf_ntaken <= '0;
        end else if (r_resolve_valid && (r_kind == 2'd0) && !r_resolve_exc) begin
            if (r_resolve_taken) begin
                r_perf_taken <= r_perf_taken + 32'd1;
            end else begin
                r_perf_ntaken <= r_perf_ntaken + 32'd1;
            end
        end
    end

    assign perf_taken_cnt_o  = r_perf_taken;
    assign perf_ntaken_cnt_o = r_perf_ntaken;
`endif

endmodule
